// File: rtl/mem_request_ctrl.sv
// Load/store sequencer in front of a word-only memory port: one request at a time,
// strobe/mfc handshake with timeout, sub-word load extraction and read-modify-write stores.
module mem_request_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_mfc
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RD, GAP, WR, RESP} state_t;

    state_t         state_reg;
    logic           req_ready_reg;
    logic           write_reg;
    logic [1:0]     size_reg;
    logic           signed_reg;
    logic [1:0]     lane_reg;
    logic [31:0]    wdata_reg;
    logic [CW-1:0]  cnt_reg;
    logic           mem_read_reg;
    logic           mem_write_reg;
    logic [31:0]    mem_addr_reg;
    logic [31:0]    mem_write_data_reg;
    logic           resp_valid_reg;
    logic [31:0]    resp_rdata_reg;
    logic           resp_error_reg;

    logic           accept;
    logic           req_bad;
    logic           timeout_hit;
    logic [31:0]    lane_shifted;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [31:0]    load_data;
    logic [3:0]     lane_en;
    logic [31:0]    store_rep;
    logic [31:0]    merged_word;

    assign accept      = (state_reg == IDLE) && req_ready_reg && req_valid;
    assign timeout_hit = (cnt_reg == CNT_LAST);

    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            2'd1:    req_bad = req_addr[0];
            2'd2:    req_bad = |req_addr[1:0];
            2'd3:    req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
    end

    // Little-endian lane extraction of the captured word, then zero/sign extension.
    always_comb begin
        lane_shifted = mem_read_data >> {lane_reg, 3'b000};
        ld_byte      = lane_shifted[7:0];
        ld_half      = lane_reg[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (size_reg)
            2'd0:    load_data = {{24{signed_reg & ld_byte[7]}}, ld_byte};
            2'd1:    load_data = {{16{signed_reg & ld_half[15]}}, ld_half};
            default: load_data = mem_read_data;
        endcase
    end

    always_comb begin
        case (size_reg)
            2'd0:    lane_en = 4'b0001 << lane_reg;
            2'd1:    lane_en = lane_reg[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
        case (size_reg)
            2'd0:    store_rep = {4{wdata_reg[7:0]}};
            2'd1:    store_rep = {2{wdata_reg[15:0]}};
            default: store_rep = wdata_reg;
        endcase
    end

    // Replace only the addressed lanes; the rest keep the value just read.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged_word[8*gi +: 8] = lane_en[gi] ? store_rep[8*gi +: 8]
                                                        : mem_read_data[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            req_ready_reg      <= 1'b0;
            write_reg          <= 1'b0;
            size_reg           <= 2'd0;
            signed_reg         <= 1'b0;
            lane_reg           <= 2'd0;
            wdata_reg          <= '0;
            cnt_reg            <= '0;
            mem_read_reg       <= 1'b0;
            mem_write_reg      <= 1'b0;
            mem_addr_reg       <= '0;
            mem_write_data_reg <= '0;
            resp_valid_reg     <= 1'b0;
            resp_rdata_reg     <= '0;
            resp_error_reg     <= 1'b0;
        end else begin
            resp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (accept) begin
                        req_ready_reg <= 1'b0;
                        write_reg     <= req_write;
                        size_reg      <= req_size;
                        signed_reg    <= req_signed;
                        lane_reg      <= req_addr[1:0];
                        wdata_reg     <= req_wdata;
                        mem_addr_reg  <= {req_addr[31:2], 2'b00};
                        cnt_reg       <= '0;
                        if (req_bad) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_error_reg <= 1'b1;
                            resp_rdata_reg <= '0;
                        end else if (req_write && (req_size == 2'd2)) begin
                            state_reg          <= WR;
                            mem_write_reg      <= 1'b1;
                            mem_write_data_reg <= req_wdata;
                        end else begin
                            state_reg    <= RD;
                            mem_read_reg <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (mem_mfc) begin
                        mem_read_reg <= 1'b0;
                        if (write_reg) begin
                            state_reg          <= GAP;
                            mem_write_data_reg <= merged_word;
                        end else begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_error_reg <= 1'b0;
                            resp_rdata_reg <= load_data;
                        end
                    end else if (timeout_hit) begin
                        mem_read_reg   <= 1'b0;
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_error_reg <= 1'b1;
                        resp_rdata_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                GAP: begin
                    state_reg     <= WR;
                    mem_write_reg <= 1'b1;
                    cnt_reg       <= '0;
                end
                WR: begin
                    if (mem_mfc || timeout_hit) begin
                        mem_write_reg  <= 1'b0;
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_error_reg <= !mem_mfc;
                        resp_rdata_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                RESP: begin
                    state_reg      <= IDLE;
                    req_ready_reg  <= 1'b1;
                    resp_error_reg <= 1'b0;
                    resp_rdata_reg <= '0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // In the accepting IDLE cycle the request address/data are shown directly, so both
    // are already stable one cycle before the strobe rises on the acceptance edge.
    assign mem_addr       = accept ? {req_addr[31:2], 2'b00} : mem_addr_reg;
    assign mem_write_data = (accept && req_write && (req_size == 2'd2)) ? req_wdata
                                                                        : mem_write_data_reg;

    assign req_ready  = req_ready_reg;
    assign mem_read   = mem_read_reg;
    assign mem_write  = mem_write_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_error = resp_error_reg;

endmodule

// File: tb/tb_mem_request_ctrl.sv
// Randomized bench for mem_request_ctrl: a memory responder with programmable mfc delay,
// a word-level reference model of each access, and a single per-cycle compare process.
module tb_mem_request_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_mfc;

    always #5 clk = ~clk;

    mem_request_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_mfc(mem_mfc)
    );

    typedef struct {
        bit          wr;
        logic [1:0]  sz;
        bit          err;
        logic [31:0] rdata;
        int          lat;
        int          reads;
        int          writes;
        logic [31:0] addr;
        logic [31:0] wword;
        int          idx;
        logic [31:0] mem_after;
        int          accept;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          mon_cyc = 0;
    int          push_cnt = 0;
    int          done_cnt = 0;
    int          rd_delay = 1;
    int          wr_delay = 1;
    exp_t        slot;
    logic [31:0] env_mem [16];
    logic [31:0] ref_mem [16];

    function automatic logic [31:0] init_word(input int i);
        return 32'h9E3779B9 * (i + 1);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a,
                                               input logic [1:0] sz, input bit sg);
        logic [31:0] v;
        logic [31:0] m;
        int bits;
        case (sz)
            2'd0:    bits = 8;
            2'd1:    bits = 16;
            default: bits = 32;
        endcase
        if (bits == 32) return w;
        m = (32'h1 << bits) - 32'h1;
        v = (w >> (8 * a)) & m;
        if (sg && v[bits-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] a, input logic [1:0] sz);
        logic [31:0] m;
        m = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * a);
        return (old & ~m) | ((wd << (8 * a)) & m);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory side: mfc rises in strobe cycle <delay> and holds until the strobe drops.
    initial begin : responder
        int scyc;
        scyc = 0;
        mem_mfc = 1'b0;
        mem_read_data = '0;
        for (int i = 0; i < 16; i++) env_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (rst_n && (mem_read || mem_write)) begin
                scyc++;
                if (scyc == (mem_read ? rd_delay : wr_delay)) begin
                    mem_mfc = 1'b1;
                    if (mem_read) mem_read_data = env_mem[mem_addr[5:2]];
                    else          env_mem[mem_addr[5:2]] = mem_write_data;
                end
            end else begin
                scyc = 0;
                mem_mfc = 1'b0;
                mem_read_data = $urandom;
            end
        end
    end

    initial begin : monitor
        exp_t        q[$];
        exp_t        cur;
        int          seen;
        int          rd_cnt;
        int          wr_cnt;
        int          since_rst;
        logic        prev_read;
        logic        prev_write;
        logic [31:0] prev_addr;
        logic [31:0] prev_wdata;
        seen = 0; rd_cnt = 0; wr_cnt = 0; since_rst = 0;
        prev_read = 1'b0; prev_write = 1'b0; prev_addr = '0; prev_wdata = '0;

        chk("pin_sbyte",  model_load(32'h80FF1234, 2'd3, 2'd0, 1'b1), 32'hFFFFFF80);
        chk("pin_ubyte",  model_load(32'h80FF1234, 2'd3, 2'd0, 1'b0), 32'h00000080);
        chk("pin_shalf",  model_load(32'h80FF1234, 2'd2, 2'd1, 1'b1), 32'hFFFF80FF);
        chk("pin_merge",  model_merge(32'h11223344, 32'h0000ABCD, 2'd2, 2'd1), 32'hABCD3344);

        forever begin
            @(negedge clk);
            mon_cyc++;
            while (seen < push_cnt) begin
                q.push_back(slot);
                seen++;
            end
            if (!rst_n) begin
                done_cnt += q.size();
                q.delete();
                rd_cnt = 0; wr_cnt = 0; since_rst = 0;
                chk("rst_mem_read",   32'(mem_read), 32'h0);
                chk("rst_mem_write",  32'(mem_write), 32'h0);
                chk("rst_resp_valid", 32'(resp_valid), 32'h0);
                chk("rst_req_ready",  32'(req_ready), 32'h0);
                chk("rst_mem_addr",   mem_addr, 32'h0);
                chk("rst_mem_wdata",  mem_write_data, 32'h0);
                chk("rst_resp_rdata", resp_rdata, 32'h0);
                chk("rst_resp_error", 32'(resp_error), 32'h0);
                prev_read = 1'b0; prev_write = 1'b0; prev_addr = '0; prev_wdata = '0;
            end else begin
                since_rst++;
                if (since_rst == 2) chk("ready_after_rst", 32'(req_ready), 32'h1);
                chk("strobe_overlap", 32'(mem_read & mem_write), 32'h0);
                if ((mem_read && !prev_read) || (mem_write && !prev_write))
                    chk("strobe_gap", 32'(prev_read | prev_write), 32'h0);
                if (mem_read || mem_write || prev_read || prev_write)
                    chk("addr_stable", mem_addr, prev_addr);
                if (mem_write || prev_write)
                    chk("wdata_stable", mem_write_data, prev_wdata);
                if (mem_read || mem_write) begin
                    chk("strobe_owner", 32'(q.size()), 32'h1);
                    if (q.size() > 0) begin
                        chk("mem_addr", mem_addr, q[0].addr);
                        if (mem_write) chk("mem_wdata", mem_write_data, q[0].wword);
                    end
                    rd_cnt += int'(mem_read);
                    wr_cnt += int'(mem_write);
                end
                if (resp_valid) begin
                    chk("resp_owner", 32'(q.size()), 32'h1);
                    if (q.size() > 0) begin
                        cur = q.pop_front();
                        done_cnt++;
                        chk("resp_error", 32'(resp_error), 32'(cur.err));
                        chk("resp_rdata", resp_rdata, cur.rdata);
                        chk("latency", 32'(mon_cyc - cur.accept), 32'(cur.lat));
                        chk("read_cycles", 32'(rd_cnt), 32'(cur.reads));
                        chk("write_cycles", 32'(wr_cnt), 32'(cur.writes));
                        chk("mem_word", env_mem[cur.idx], cur.mem_after);
                        $display("txn %0d: addr=%h wr=%0d size=%0d err=%0d rdata=%h lat=%0d",
                                 done_cnt, cur.addr, cur.wr, cur.sz, resp_error, resp_rdata,
                                 mon_cyc - cur.accept);
                    end
                    rd_cnt = 0; wr_cnt = 0;
                end else if (q.size() > 0 && (mon_cyc - q[0].accept) > 60) begin
                    chk("resp_timeout", 32'(resp_valid), 32'h1);
                    void'(q.pop_front());
                    done_cnt++;
                    rd_cnt = 0; wr_cnt = 0;
                end
                prev_read = mem_read; prev_write = mem_write;
                prev_addr = mem_addr; prev_wdata = mem_write_data;
            end
        end
    end

    task automatic do_txn(input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int rd_d, input int wr_d, input bit abort);
        exp_t        e;
        logic [31:0] old;
        bit          bad;
        int          pre;
        int          n;
        e.idx = int'(a[5:2]);
        old = ref_mem[e.idx];
        bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        e.wr = wr; e.sz = sz; e.err = 1'b0; e.rdata = '0; e.reads = 0; e.writes = 0;
        e.addr = {a[31:2], 2'b00}; e.wword = '0; e.mem_after = old; e.lat = 0;
        if (bad) begin
            e.err = 1'b1; e.lat = 1;
        end else if (!wr) begin
            if (rd_d > TO) begin
                e.err = 1'b1; e.reads = TO; e.lat = TO + 1;
            end else begin
                e.reads = rd_d; e.lat = rd_d + 1;
                e.rdata = model_load(old, a[1:0], sz, sg);
            end
        end else begin
            e.wword = (sz == 2'd2) ? wd : model_merge(old, wd, a[1:0], sz);
            pre = 0;
            if (sz != 2'd2 && rd_d > TO) begin
                e.err = 1'b1; e.reads = TO; e.lat = TO + 1;
            end else begin
                if (sz != 2'd2) begin
                    e.reads = rd_d; pre = rd_d + 1;
                end
                e.writes = (wr_d > TO) ? TO : wr_d;
                e.lat = pre + e.writes + 1;
                if (wr_d > TO) e.err = 1'b1;
                else           e.mem_after = e.wword;
            end
        end

        rd_delay = rd_d;
        wr_delay = wr_d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!req_ready && n < 50);
        if (!req_ready) begin
            $display("FAIL ready_wait: req_ready=%0d required 1", req_ready);
            $fatal(1, "controller never became ready");
        end
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        e.accept = mon_cyc;
        slot = e;
        push_cnt++;

        if (abort) begin
            n = 0;
            while (!mem_write && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (!mem_write) begin
                $display("FAIL abort_wait: mem_write=%0d required 1", mem_write);
                $fatal(1, "write strobe never reached");
            end
            #1 rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
        end else begin
            n = 0;
            while (done_cnt != push_cnt && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            if (done_cnt != push_cnt) begin
                $display("FAIL txn_wait: done=%0d required %0d", done_cnt, push_cnt);
                $fatal(1, "response never accounted");
            end
            ref_mem[e.idx] = e.mem_after;
        end
    endtask

    initial begin : driver
        logic        rwr;
        logic [1:0]  rsz;
        logic        rsg;
        logic [31:0] raddr;
        int          rrd;
        int          rwd;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        do_txn(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 1, 1, 1'b0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 3, 1, 1'b0);
        do_txn(1'b1, 2'd2, 1'b0, 32'h100, 32'h80FF1234, 1, 2, 1'b0);
        do_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1, 1, 1'b0);
        do_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1, 1, 1'b0);
        do_txn(1'b1, 2'd2, 1'b0, 32'h200, 32'h11223344, 1, 1, 1'b0);
        do_txn(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, 1, 1, 1'b0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 1, 1, 1'b0);
        do_txn(1'b0, 2'd1, 1'b0, 32'h301, 32'h0, 1, 1, 1'b0);
        do_txn(1'b0, 2'd3, 1'b0, 32'h300, 32'h0, 1, 1, 1'b0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5, 1, 1'b0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 4, 1, 1'b0);
        do_txn(1'b1, 2'd2, 1'b0, 32'h104, 32'h00000001, 1, 5, 1'b0);
        do_txn(1'b1, 2'd0, 1'b0, 32'h105, 32'h0000005A, 1, 9, 1'b1);
        do_txn(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 1, 1, 1'b0);

        for (int t = 0; t < 150; t++) begin
            rwr = 1'($urandom_range(0, 1));
            rsz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rsg = 1'($urandom_range(0, 1));
            raddr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (rsz == 2'd1) raddr[0] = 1'b0;
                if (rsz == 2'd2) raddr[1:0] = 2'd0;
            end
            rrd = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(1, 4);
            rwd = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(1, 4);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_txn(rwr, rsz, rsg, raddr, $urandom, rrd, rwd, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_request_ctrl.md
# mem_request_ctrl

Sequencer between the core's load/store path and `mem_interface`. It accepts one request at a time and drives the `read`/`write` strobes, address and data. It waits for `mfc` and returns aligned, extended read data. Sub-word stores become word read-modify-write sequences, because the memory side is word-only with no byte enables.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles a strobe is held waiting for `mfc` before the access is aborted with an error (≥2).
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `req_valid` input 1: core request present.
- `req_ready` output 1: controller can accept (IDLE only).
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- `req_signed` input 1: sign-extend loaded sub-word data.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 32: load result, extended; 0 for stores and errors.
- `resp_error` output 1: misaligned, reserved size, or timeout; valid with `resp_valid`.
- `mem_read` output 1: to `mem_interface.read`.
- `mem_write` output 1: to `mem_interface.write`.
- `mem_addr` output 32: word address, {req_addr[31:2], 2'b00}.
- `mem_write_data` output 32: full word to write.
- `mem_read_data` input 32: from `mem_interface.read_data`.
- `mem_mfc` input 1: from `mem_interface.mfc`, level, sampled on `clk`.

## Operation
- States: IDLE, RD, GAP, WR, RESP.
- IDLE: `req_ready`=1. On `req_valid` the controller latches all request fields and checks alignment. A half access needs addr[0]=0 and a word access needs addr[1:0]=0.
  - Misaligned or size 3 → RESP with error; no strobe is issued.
  - Load → RD.
  - Word store → WR, with `mem_write_data` = `req_wdata`.
  - Byte/half store → RD (RMW read).
- RD: `mem_read`=1. On sampled `mem_mfc`=1 the controller captures `mem_read_data`.
  - Load → RESP.
  - RMW → GAP.
- GAP: both strobes 0 for exactly one cycle. The controller merges the store data into the captured word at lane addr[1:0], then goes to WR.
- WR: `mem_write`=1. On sampled `mem_mfc`=1 → RESP.
- RESP: `resp_valid`=1 for one cycle, then IDLE. No back-pressure: the core must take the response.
- Load extraction is little-endian. Lane n occupies bits [8n+7:8n]; a half at addr[1]=1 uses [31:16]. Result is zero-extended, or sign-extended when `req_signed`=1.
- Merge: only the addressed byte/half is replaced; the other bytes keep the read value.
- Timeout: the counter clears on entering RD or WR and increments each cycle `mem_mfc`=0.
  - If the count reaches TIMEOUT_CYCLES-1 with `mem_mfc`=0, the strobe drops and the state goes to RESP with error.
  - An RMW timeout in RD skips the write.
  - `mem_mfc`=1 in the final cycle counts as success.

## Timing
- Reset (async) values:
  - State IDLE.
  - `mem_read`, `mem_write`, `mem_addr`, `mem_write_data`, `resp_valid`, `resp_rdata`, `resp_error` all 0.
  - `req_ready`=0 while `rst_n`=0, and 1 from the first cycle after release.
- Reset mid-access: strobes fall immediately, no response is issued, and the latched request is discarded.
- `mem_addr` and `mem_write_data` are stable from one cycle before a strobe rises until after it falls. They change only in IDLE, GAP or RESP.
- Every strobe assertion is preceded by ≥1 cycle with both strobes 0. This guarantees `mem_interface` has cleared `mfc` before a new strobe. The read and write strobes are never high together.
- Latency, from acceptance edge to `resp_valid`, with `mfc` returned in the first strobe cycle:
  - Word load/store: 2 cycles.
  - Sub-word store: 4 cycles.
  - Error without access: 1 cycle.
- Throughput: the next request is accepted no earlier than the cycle after RESP.

## Test plan
- Word load from 0x100 with memory returning 0xDEADBEEF after 3 cycles → `mem_read` high 3 cycles, then `resp_rdata`=0xDEADBEEF, `resp_error`=0.
- Signed byte load from 0x103, word 0x80FF1234 → `mem_addr`=0x100, `resp_rdata`=0xFFFFFF80. Unsigned load gives 0x00000080.
- Half store 0xABCD to 0x202, memory word 0x11223344 → read, one GAP cycle, then write of 0xABCD3344 to 0x200. Response has `resp_error`=0.
- Half load at 0x301 and size-3 request → `resp_error`=1 one cycle after acceptance, no strobe ever asserted.
- TIMEOUT_CYCLES=4 with `mfc` never set → `mem_read` high exactly 4 cycles, then `resp_error`=1. With `mfc` rising in the 4th cycle → success.
- `rst_n` pulled low during WR → `mem_write` drops without waiting for a clock, no `resp_valid` is issued, and the controller is ready after release.
